tt_ecp5_proj_sel: RTL and testbench

TT_ECP5_PROJ_SEL -- requirements
Module: tt_ecp5_proj_sel

---
 rtl/tt_ecp5_proj_sel.sv | 228 ++++++++++++++++++++++
 tb/tb_tt_ecp5_proj_sel.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_ecp5_proj_sel.sv
// ---------------------------------------------------------------------------
// tt_ecp5_proj_sel
//
// Selects one of four Tiny Tapeout style projects onto the board pins. A switch
// is a three-phase sequence: RUN -> QUIESCE -> RESET -> RUN.
//   QUIESCE : the outgoing project is held in reset with pins released, so it
//             stops driving before anything else changes.
//   RESET   : ena moves to the incoming project, which is held in reset for
//             RST_CYCLES cycles before it is released and its pins connected.
// One 8-bit down-counter times both QUIESCE and RESET.
//
// Ports
//   clk, rst        sole clock, synchronous active-high reset
//   sel_valid       single-cycle select strobe; sel_req (0..3) sampled with it
//   proj_uo_out     project uo_out buses, project k on [8k+7:8k]
//   proj_uio_out    project uio_out buses, same packing
//   proj_uio_oe     project uio_oe buses, same packing
//   proj_ena        one-hot ena to projects (registered)
//   proj_rst_n      active-low reset to projects (registered)
//   uo_out          board dedicated outputs
//   uio_out/uio_oe  board bidir data / output enables (1 = drive)
//   cur_sel         index of the current project (registered)
//   busy            high while a switch or reset is in progress
//   req_dropped     one-cycle pulse after a request arriving while busy
// ---------------------------------------------------------------------------
module tt_ecp5_proj_sel #(
    parameter int RST_CYCLES     = 16,  // legal 2..255
    parameter int QUIESCE_CYCLES = 4    // legal 1..255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel_valid,
    input  logic [1:0]  sel_req,
    input  logic [31:0] proj_uo_out,
    input  logic [31:0] proj_uio_out,
    input  logic [31:0] proj_uio_oe,
    output logic [3:0]  proj_ena,
    output logic [3:0]  proj_rst_n,
    output logic [7:0]  uo_out,
    output logic [7:0]  uio_out,
    output logic [7:0]  uio_oe,
    output logic [1:0]  cur_sel,
    output logic        busy,
    output logic        req_dropped
);

    localparam int NUM_PROJ = 4;

    // Counter reload values: a phase of N cycles starts at N-1 and ends on 0.
    localparam logic [7:0] Q_LOAD = 8'(QUIESCE_CYCLES - 1);
    localparam logic [7:0] R_LOAD = 8'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_QUIESCE = 2'd1,
        ST_RESET   = 2'd2
    } state_t;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

    state_t     state_q, state_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [1:0] pend_q,  pend_d;
    logic [1:0] sel_q,   sel_d;
    logic [3:0] ena_q,   ena_d;
    logic [3:0] rstn_q,  rstn_d;
    logic       drop_q,  drop_d;

    logic       cnt_zero;
    assign cnt_zero = (cnt_q == 8'd0);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        sel_d   = sel_q;
        ena_d   = ena_q;
        rstn_d  = rstn_q;
        drop_d  = 1'b0;

        case (state_q)
            ST_RUN: begin
                // Reselecting the current project is accepted too: it simply
                // re-resets that project.
                if (sel_valid) begin
                    state_d = ST_QUIESCE;
                    pend_d  = sel_req;
                    cnt_d   = Q_LOAD;
                    rstn_d  = 4'b0000;
                end
            end

            ST_QUIESCE: begin
                drop_d = sel_valid;
                if (cnt_zero) begin
                    // ena moves only once the old project has sat in reset
                    // with pins released for the full quiesce window.
                    state_d = ST_RESET;
                    sel_d   = pend_q;
                    ena_d   = onehot(pend_q);
                    rstn_d  = 4'b0000;
                    cnt_d   = R_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            ST_RESET: begin
                drop_d = sel_valid;
                if (cnt_zero) begin
                    state_d = ST_RUN;
                    rstn_d  = onehot(sel_q);
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            default: begin
                // Unreachable encoding: fall back to a clean reset of the
                // current project.
                state_d = ST_RESET;
                cnt_d   = R_LOAD;
                ena_d   = onehot(sel_q);
                rstn_d  = 4'b0000;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers. Reset aborts any switch in flight and discards pending.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RESET;
            cnt_q   <= R_LOAD;
            pend_q  <= 2'd0;
            sel_q   <= 2'd0;
            ena_q   <= 4'b0001;
            rstn_q  <= 4'b0000;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            sel_q   <= sel_d;
            ena_q   <= ena_d;
            rstn_q  <= rstn_d;
            drop_q  <= drop_d;
        end
    end

    assign proj_ena    = ena_q;
    assign proj_rst_n  = rstn_q;
    assign cur_sel     = sel_q;
    assign busy        = (state_q != ST_RUN);
    assign req_dropped = drop_q;

    // -----------------------------------------------------------------------
    // Pin mux: each lane passes its project's pins only when it is the
    // running project; the board pins are the OR of all lanes, so every pin
    // (including uio_oe) is zero whenever no lane is live.
    // -----------------------------------------------------------------------
    logic [NUM_PROJ-1:0][7:0] src_uo, src_uio, src_oe;
    logic [NUM_PROJ-1:0][7:0] lane_uo, lane_uio, lane_oe;
    logic [NUM_PROJ-1:0]      lane_on;

    assign src_uo  = proj_uo_out;
    assign src_uio = proj_uio_out;
    assign src_oe  = proj_uio_oe;

    for (genvar k = 0; k < NUM_PROJ; k++) begin : g_lane
        assign lane_on[k] = (state_q == ST_RUN) && (sel_q == 2'(k));

        tt_ecp5_proj_lane u_lane (
            .lane_on (lane_on[k]),
            .src_uo  (src_uo[k]),
            .src_uio (src_uio[k]),
            .src_oe  (src_oe[k]),
            .uo      (lane_uo[k]),
            .uio     (lane_uio[k]),
            .oe      (lane_oe[k])
        );
    end

    always_comb begin
        uo_out  = 8'h00;
        uio_out = 8'h00;
        uio_oe  = 8'h00;
        for (int k = 0; k < NUM_PROJ; k++) begin
            uo_out  = uo_out  | lane_uo[k];
            uio_out = uio_out | lane_uio[k];
            uio_oe  = uio_oe  | lane_oe[k];
        end
    end

endmodule

// ---------------------------------------------------------------------------
// tt_ecp5_proj_lane
//
// One project's pin gate: forwards the project's uo/uio/oe bytes when
// lane_on is high, otherwise drives zeros (pins released).
//
// Ports
//   lane_on                 this project is live on the board
//   src_uo, src_uio, src_oe the project's own pin bytes
//   uo, uio, oe             gated bytes, OR-combined by the parent
// ---------------------------------------------------------------------------
module tt_ecp5_proj_lane (
    input  logic       lane_on,
    input  logic [7:0] src_uo,
    input  logic [7:0] src_uio,
    input  logic [7:0] src_oe,
    output logic [7:0] uo,
    output logic [7:0] uio,
    output logic [7:0] oe
);

    assign uo  = lane_on ? src_uo  : 8'h00;
    assign uio = lane_on ? src_uio : 8'h00;
    assign oe  = lane_on ? src_oe  : 8'h00;

endmodule

// File: tb/tb_tt_ecp5_proj_sel.sv
module tb_tt_ecp5_proj_sel;

    localparam int Q = 4;
    localparam int R = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel_valid;
    logic [1:0]  sel_req;
    logic [31:0] proj_uo_out, proj_uio_out, proj_uio_oe;
    logic [3:0]  proj_ena, proj_rst_n;
    logic [7:0]  uo_out, uio_out, uio_oe;
    logic [1:0]  cur_sel;
    logic        busy, req_dropped;

    int checks = 0;
    int errors = 0;

    tt_ecp5_proj_sel #(.RST_CYCLES(R), .QUIESCE_CYCLES(Q)) dut (
        .clk          (clk),
        .rst          (rst),
        .sel_valid    (sel_valid),
        .sel_req      (sel_req),
        .proj_uo_out  (proj_uo_out),
        .proj_uio_out (proj_uio_out),
        .proj_uio_oe  (proj_uio_oe),
        .proj_ena     (proj_ena),
        .proj_rst_n   (proj_rst_n),
        .uo_out       (uo_out),
        .uio_out      (uio_out),
        .uio_oe       (uio_oe),
        .cur_sel      (cur_sel),
        .busy         (busy),
        .req_dropped  (req_dropped)
    );

    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Reference model: a switch is described by the cycle it started in, the
    // outgoing and incoming project, and whether it has a quiesce window
    // (a plain reset has none). Everything observable follows from the
    // distance between the current cycle and the start cycle.
    // -----------------------------------------------------------------------
    int cyc      = 0;
    int sw_start = 0;
    bit has_q    = 1'b0;
    int m_old    = 0;
    int m_new    = 0;

    // 0 = running, 1 = quiescing, 2 = holding new project in reset
    function automatic int phase_of(input int c);
        int k;
        k = c - sw_start;
        if (has_q) begin
            if (k < Q)     return 1;
            if (k < Q + R) return 2;
            return 0;
        end
        if (k < R) return 2;
        return 0;
    endfunction

    always @(posedge clk) begin
        bit         rst_s, sv_s;
        logic [1:0] sr_s;
        int         ph_prev, ph, exp_cur;
        logic [3:0] exp_ena, exp_rstn;
        logic [7:0] exp_uo, exp_uio, exp_oe;
        bit         exp_busy, exp_drop;

        rst_s   = rst;
        sv_s    = sel_valid;
        sr_s    = sel_req;
        ph_prev = phase_of(cyc);
        cyc++;
        if (rst_s) begin
            has_q    = 1'b0;
            m_old    = 0;
            m_new    = 0;
            sw_start = cyc;
            exp_drop = 1'b0;
        end else begin
            exp_drop = sv_s && (ph_prev != 0);
            if (sv_s && ph_prev == 0) begin
                has_q    = 1'b1;
                m_old    = m_new;
                m_new    = int'(sr_s);
                sw_start = cyc;
            end
        end
        ph       = phase_of(cyc);
        exp_cur  = (ph == 1) ? m_old : m_new;
        exp_ena  = 4'b0001 << exp_cur;
        exp_rstn = (ph == 0) ? (4'b0001 << m_new) : 4'b0000;
        exp_busy = (ph != 0);

        #1;
        exp_uo  = (ph == 0) ? proj_uo_out[8*m_new +: 8]  : 8'h00;
        exp_uio = (ph == 0) ? proj_uio_out[8*m_new +: 8] : 8'h00;
        exp_oe  = (ph == 0) ? proj_uio_oe[8*m_new +: 8]  : 8'h00;

        checks++;
        if (proj_ena !== exp_ena) begin
            errors++;
            $display("FAIL mon_ena cyc=%0d got=%b exp=%b", cyc, proj_ena, exp_ena);
        end
        checks++;
        if (proj_rst_n !== exp_rstn) begin
            errors++;
            $display("FAIL mon_rst_n cyc=%0d got=%b exp=%b", cyc, proj_rst_n, exp_rstn);
        end
        checks++;
        if (cur_sel !== 2'(exp_cur)) begin
            errors++;
            $display("FAIL mon_cur_sel cyc=%0d got=%0d exp=%0d", cyc, cur_sel, exp_cur);
        end
        checks++;
        if (busy !== exp_busy) begin
            errors++;
            $display("FAIL mon_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
        end
        checks++;
        if (req_dropped !== exp_drop) begin
            errors++;
            $display("FAIL mon_drop cyc=%0d got=%b exp=%b", cyc, req_dropped, exp_drop);
        end
        checks++;
        if (uo_out !== exp_uo || uio_out !== exp_uio || uio_oe !== exp_oe) begin
            errors++;
            $display("FAIL mon_pins cyc=%0d got=%h/%h/%h exp=%h/%h/%h",
                     cyc, uo_out, uio_out, uio_oe, exp_uo, exp_uio, exp_oe);
        end
        // Structural invariants, independent of the model
        checks++;
        if ($countones(proj_ena) != 1 || $countones(proj_rst_n) > 1) begin
            errors++;
            $display("FAIL inv_onehot cyc=%0d got ena=%b rst_n=%b exp ena one-hot, rst_n <=1 bit",
                     cyc, proj_ena, proj_rst_n);
        end
        checks++;
        if (busy === 1'b1 && uio_oe !== 8'h00) begin
            errors++;
            $display("FAIL inv_oe_busy cyc=%0d got=%h exp=00", cyc, uio_oe);
        end

        // New project pin values for the next cycle
        #1;
        proj_uo_out  = $urandom;
        proj_uio_out = $urandom;
        proj_uio_oe  = $urandom;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // -----------------------------------------------------------------------
    // Scenarios (all stimulus driven on the falling edge)
    // -----------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; sel_valid = 1'b0; sel_req = 2'd0;
        wait_cyc(3);
        checks++;
        if (proj_ena !== 4'b0001 || proj_rst_n !== 4'b0000 || cur_sel !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_state got ena=%b rst_n=%b cur=%0d busy=%b exp 0001/0000/0/1",
                     proj_ena, proj_rst_n, cur_sel, busy);
        end
        checks++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'h00) begin
            errors++;
            $display("FAIL rst_pins got=%h/%h/%h exp=00/00/00", uo_out, uio_out, uio_oe);
        end
        // A request during reset is not a dropped request
        sel_valid = 1'b1; sel_req = 2'd3;
        wait_cyc(1);
        sel_valid = 1'b0;
        checks++;
        if (req_dropped !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_drop got=%b exp=0", req_dropped);
        end
        wait_cyc(1);
        rst = 1'b0;               // this cycle is reset cycle 1
        wait_cyc(R - 1);
        checks++;
        if (busy !== 1'b1 || proj_rst_n !== 4'b0000) begin
            errors++;
            $display("FAIL rst_last_busy got busy=%b rst_n=%b exp 1/0000", busy, proj_rst_n);
        end
        wait_cyc(1);
        checks++;
        if (busy !== 1'b0 || proj_ena !== 4'b0001 || proj_rst_n !== 4'b0001) begin
            errors++;
            $display("FAIL rst_run got busy=%b ena=%b rst_n=%b exp 0/0001/0001", busy, proj_ena, proj_rst_n);
        end
        checks++;
        if (uo_out !== proj_uo_out[7:0]) begin
            errors++;
            $display("FAIL rst_run_uo got=%h exp=%h", uo_out, proj_uo_out[7:0]);
        end
    endtask

    task automatic test_switch_0_to_2();
        sel_valid = 1'b1; sel_req = 2'd2;      // cycle T
        wait_cyc(1);                            // T+1
        sel_valid = 1'b0;
        checks++;
        if (proj_rst_n !== 4'b0000 || proj_ena !== 4'b0001 || busy !== 1'b1 ||
            uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'h00) begin
            errors++;
            $display("FAIL sw02_t1 got rst_n=%b ena=%b busy=%b pins=%h/%h/%h exp 0000/0001/1/00/00/00",
                     proj_rst_n, proj_ena, busy, uo_out, uio_out, uio_oe);
        end
        wait_cyc(3);                            // T+4
        checks++;
        if (proj_rst_n !== 4'b0000 || proj_ena !== 4'b0001 || uio_oe !== 8'h00) begin
            errors++;
            $display("FAIL sw02_t4 got rst_n=%b ena=%b oe=%h exp 0000/0001/00", proj_rst_n, proj_ena, uio_oe);
        end
        wait_cyc(1);                            // T+5
        checks++;
        if (proj_ena !== 4'b0100 || cur_sel !== 2'd2 || proj_rst_n !== 4'b0000) begin
            errors++;
            $display("FAIL sw02_t5 got ena=%b cur=%0d rst_n=%b exp 0100/2/0000", proj_ena, cur_sel, proj_rst_n);
        end
        wait_cyc(15);                           // T+20
        checks++;
        if (busy !== 1'b1 || proj_rst_n !== 4'b0000) begin
            errors++;
            $display("FAIL sw02_t20 got busy=%b rst_n=%b exp 1/0000", busy, proj_rst_n);
        end
        wait_cyc(1);                            // T+21
        checks++;
        if (proj_rst_n !== 4'b0100 || busy !== 1'b0 || uio_oe !== proj_uio_oe[23:16]) begin
            errors++;
            $display("FAIL sw02_t21 got rst_n=%b busy=%b oe=%h exp 0100/0/%h",
                     proj_rst_n, busy, uio_oe, proj_uio_oe[23:16]);
        end
    endtask

    task automatic test_reselect_same();
        sel_valid = 1'b1; sel_req = 2'd1;
        wait_cyc(1); sel_valid = 1'b0;
        wait_cyc(20);
        checks++;
        if (cur_sel !== 2'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL same_setup got cur=%0d busy=%b exp 1/0", cur_sel, busy);
        end
        sel_valid = 1'b1; sel_req = 2'd1;      // T
        wait_cyc(1); sel_valid = 1'b0;          // T+1
        checks++;
        if (proj_rst_n !== 4'b0000 || proj_ena !== 4'b0010 || busy !== 1'b1) begin
            errors++;
            $display("FAIL same_t1 got rst_n=%b ena=%b busy=%b exp 0000/0010/1", proj_rst_n, proj_ena, busy);
        end
        wait_cyc(4);                            // T+5
        checks++;
        if (proj_ena !== 4'b0010 || cur_sel !== 2'd1 || proj_rst_n !== 4'b0000) begin
            errors++;
            $display("FAIL same_t5 got ena=%b cur=%0d rst_n=%b exp 0010/1/0000", proj_ena, cur_sel, proj_rst_n);
        end
        wait_cyc(16);                           // T+21
        checks++;
        if (proj_rst_n !== 4'b0010 || busy !== 1'b0 || uo_out !== proj_uo_out[15:8]) begin
            errors++;
            $display("FAIL same_t21 got rst_n=%b busy=%b uo=%h exp 0010/0/%h",
                     proj_rst_n, busy, uo_out, proj_uo_out[15:8]);
        end
    endtask

    task automatic test_drop_during_reset();
        sel_valid = 1'b1; sel_req = 2'd2;      // T
        wait_cyc(1); sel_valid = 1'b0;          // T+1
        wait_cyc(7);                            // T+8, inside RESET
        sel_valid = 1'b1; sel_req = 2'd3;
        wait_cyc(1); sel_valid = 1'b0;          // T+9
        checks++;
        if (req_dropped !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL drop_pulse got drop=%b busy=%b exp 1/1", req_dropped, busy);
        end
        wait_cyc(1);                            // T+10
        checks++;
        if (req_dropped !== 1'b0) begin
            errors++;
            $display("FAIL drop_once got=%b exp=0", req_dropped);
        end
        wait_cyc(11);                           // T+21
        checks++;
        if (cur_sel !== 2'd2 || proj_ena !== 4'b0100 || proj_rst_n !== 4'b0100 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_done got cur=%0d ena=%b rst_n=%b busy=%b exp 2/0100/0100/0",
                     cur_sel, proj_ena, proj_rst_n, busy);
        end
    endtask

    task automatic test_rst_mid_quiesce();
        sel_valid = 1'b1; sel_req = 2'd0;
        wait_cyc(1); sel_valid = 1'b0;
        wait_cyc(20);
        sel_valid = 1'b1; sel_req = 2'd3;      // T
        wait_cyc(1); sel_valid = 1'b0;          // T+1
        wait_cyc(1);                            // T+2, quiesce cycle 2
        rst = 1'b1;
        wait_cyc(1);                            // T+3
        checks++;
        if (cur_sel !== 2'd0 || proj_ena !== 4'b0001 || proj_rst_n !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_state got cur=%0d ena=%b rst_n=%b busy=%b exp 0/0001/0000/1",
                     cur_sel, proj_ena, proj_rst_n, busy);
        end
        rst = 1'b0;                             // reset cycle 1
        for (int i = 1; i < R; i++) begin
            wait_cyc(1);
            checks++;
            if (proj_ena[3] !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL abort_hold i=%0d got ena=%b busy=%b exp ena[3]=0 busy=1", i, proj_ena, busy);
            end
        end
        wait_cyc(1);
        checks++;
        if (busy !== 1'b0 || cur_sel !== 2'd0 || proj_ena !== 4'b0001 || proj_rst_n !== 4'b0001) begin
            errors++;
            $display("FAIL abort_run got busy=%b cur=%0d ena=%b rst_n=%b exp 0/0/0001/0001",
                     busy, cur_sel, proj_ena, proj_rst_n);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 299) == 0);
            sel_valid = ($urandom_range(0, 9) == 0);
            sel_req   = 2'($urandom_range(0, 3));
        end
        @(negedge clk);
        rst = 1'b0; sel_valid = 1'b0;
        wait_cyc(Q + R + 2);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rand_settle got busy=%b exp 0", busy);
        end
    endtask

    initial begin
        rst          = 1'b1;
        sel_valid    = 1'b0;
        sel_req      = 2'd0;
        proj_uo_out  = $urandom;
        proj_uio_out = $urandom;
        proj_uio_oe  = $urandom;

        test_reset();
        test_switch_0_to_2();
        test_reselect_same();
        test_drop_during_reset();
        test_rst_mid_quiesce();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
